// File: rtl/if_stage_pkg.sv
// Shared pipeline constants and register payload types for the fetch stage and later stages.
package if_stage_pkg;

    localparam int unsigned DATA_LEN    = 32;
    localparam int unsigned ADDRESS_LEN = 32;
    localparam int unsigned PC_STEP     = 4;
    localparam int unsigned REG_ADDR_LEN = 4;
    localparam int unsigned ALU_CMD_LEN  = 4;

    localparam logic [ADDRESS_LEN-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [DATA_LEN-1:0]    NOP_INSTR        = 32'h0000_0000;

    // IF/ID payload; all-zero is the bubble
    typedef struct packed {
        logic [ADDRESS_LEN-1:0] pc;
        logic [DATA_LEN-1:0]    instr;
        logic                   valid;
    } if_id_t;

    localparam int unsigned IF_ID_LEN = $bits(if_id_t);

    // Field widths reused by the ID/EXE and EXE/MEM registers
    localparam int unsigned ID_EXE_LEN  = ADDRESS_LEN + 2 * DATA_LEN + REG_ADDR_LEN + ALU_CMD_LEN + 1;
    localparam int unsigned EXE_MEM_LEN = DATA_LEN + DATA_LEN + REG_ADDR_LEN + 1;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/branch controls, instruction-memory port and IF/ID outputs.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                   freeze;
    logic                   branch_taken;
    logic [ADDRESS_LEN-1:0] branch_addr;
    logic [ADDRESS_LEN-1:0] imem_addr;
    logic [DATA_LEN-1:0]    imem_data;
    logic [ADDRESS_LEN-1:0] id_pc;
    logic [DATA_LEN-1:0]    id_instr;
    logic                   id_valid;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_data,
        output imem_addr, id_pc, id_instr, id_valid
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_data,
        input  imem_addr, id_pc, id_instr, id_valid
    );
endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register with priority flush > hold > load; flush and reset clear to zero.
module if_id_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             hold,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDRESS_LEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    if_stage_if.master bus
);

    logic [ADDRESS_LEN-1:0] pc_q;
    logic [ADDRESS_LEN-1:0] pc_d;
    logic [ADDRESS_LEN-1:0] pc_plus4;
    logic [ADDRESS_LEN-1:0] target;
    if_id_t                 if_id_d;
    if_id_t                 if_id_q;

    assign pc_plus4 = pc_q + ADDRESS_LEN'(PC_STEP);
    // Branch targets are word aligned; low bits of the request are ignored
    assign target   = bus.branch_addr & ~ADDRESS_LEN'(3);

    // Next PC: branch beats freeze beats sequential fetch
    always_comb begin
        pc_d = pc_plus4;
        if (bus.branch_taken) begin
            pc_d = target;
        end else if (bus.freeze) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        if_id_d       = '0;
        if_id_d.pc    = pc_plus4;
        if_id_d.instr = bus.imem_data;
        if_id_d.valid = 1'b1;
    end

    if_id_reg #(
        .WIDTH (IF_ID_LEN)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.branch_taken),
        .hold  (bus.freeze),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign bus.imem_addr = pc_q;
    assign bus.id_pc     = if_id_q.pc;
    assign bus.id_instr  = if_id_q.instr;
    assign bus.id_valid  = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small combinational instruction-memory model.
module tb_if_stage;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    if_stage_if bus ();

    if_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a few known words, otherwise an address-tagged filler
    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'hE3A0_0014;
            32'h0000_0040: return 32'hE480_1000;
            default:       return 32'hE1A0_0000 | {16'h0000, addr[15:0]};
        endcase
    endfunction

    always_comb bus.imem_data = imem_word(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] id_pc,
                               input logic [31:0] instr, input logic valid);
        check({tag, ".imem_addr"}, bus.imem_addr, pc);
        check({tag, ".id_pc"},     bus.id_pc,     id_pc);
        check({tag, ".id_instr"},  bus.id_instr,  instr);
        check({tag, ".id_valid"},  32'(bus.id_valid), 32'(valid));
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n            = 1'b0;
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = '0;

        #2;
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        #1 rst_n = 1'b1;

        // Free run from reset
        tick(); check_state("run1", 32'h4, 32'h4, 32'hE3A0_0014, 1'b1);
        tick(); check_state("run2", 32'h8, 32'h8, imem_word(32'h4), 1'b1);
        tick(); check_state("run3", 32'hC, 32'hC, imem_word(32'h8), 1'b1);

        // Two-cycle freeze at pc=12
        bus.freeze = 1'b1;
        tick(); check_state("frz1", 32'hC, 32'hC, imem_word(32'h8), 1'b1);
        tick(); check_state("frz2", 32'hC, 32'hC, imem_word(32'h8), 1'b1);
        bus.freeze = 1'b0;
        tick(); check_state("unfrz", 32'h10, 32'h10, imem_word(32'hC), 1'b1);
        tick(); check_state("run4", 32'h14, 32'h14, imem_word(32'h10), 1'b1);

        // Branch at pc=20 to 0x40: one bubble, then target
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h40;
        tick(); check_state("br", 32'h40, 32'h0, 32'h0, 1'b0);
        bus.branch_taken = 1'b0;
        tick(); check_state("br_tgt", 32'h44, 32'h44, 32'hE480_1000, 1'b1);

        // Branch and freeze together, misaligned target
        bus.branch_taken = 1'b1;
        bus.freeze       = 1'b1;
        bus.branch_addr  = 32'h43;
        tick(); check_state("br_frz", 32'h40, 32'h0, 32'h0, 1'b0);
        bus.branch_taken = 1'b0;
        tick(); check_state("frz_bubble", 32'h40, 32'h0, 32'h0, 1'b0);
        bus.freeze = 1'b0;

        // Branch to top of address space, then wrap
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'hFFFF_FFFC;
        tick(); check_state("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        bus.branch_taken = 1'b0;
        tick(); check_state("wrap", 32'h0, 32'h0, imem_word(32'hFFFF_FFFC), 1'b1);

        // Run up to pc=0x20, freeze, then async reset between edges
        for (int i = 0; i < 8; i++) tick();
        check_state("run_20", 32'h20, 32'h20, imem_word(32'h1C), 1'b1);
        bus.freeze = 1'b1;
        tick(); check_state("frz_20", 32'h20, 32'h20, imem_word(32'h1C), 1'b1);
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        #1 rst_n = 1'b1;
        bus.freeze = 1'b0;
        tick(); check_state("restart", 32'h4, 32'h4, 32'hE3A0_0014, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
